// File: rtl/sram_rw_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sram_rw_arbiter_if                                         |
// | Purpose : Bundles the two requester ports, the single-port SRAM      |
// |           command/read-data bus and the init_done flag.              |
// | Ports   : a_/b_ req_valid/ready/write/addr/wmask/wdata,              |
// |           a_/b_ resp_valid/resp_data, sram_en/wmode/addr/wmask/      |
// |           wdata, sram_rdata, init_done                               |
// | Modports: slave  - arbiter view                                      |
// |           master - requester + SRAM side view                        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface sram_rw_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 80,
   parameter int LANES  = 4
) ();
   logic              a_req_valid;
   logic              a_req_ready;
   logic              a_req_write;
   logic [ADDR_W-1:0] a_req_addr;
   logic [LANES-1:0]  a_req_wmask;
   logic [DATA_W-1:0] a_req_wdata;
   logic              a_resp_valid;
   logic [DATA_W-1:0] a_resp_data;

   logic              b_req_valid;
   logic              b_req_ready;
   logic              b_req_write;
   logic [ADDR_W-1:0] b_req_addr;
   logic [LANES-1:0]  b_req_wmask;
   logic [DATA_W-1:0] b_req_wdata;
   logic              b_resp_valid;
   logic [DATA_W-1:0] b_resp_data;

   logic              sram_en;
   logic              sram_wmode;
   logic [ADDR_W-1:0] sram_addr;
   logic [LANES-1:0]  sram_wmask;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   logic              init_done;

   modport slave (
      input  a_req_valid, a_req_write, a_req_addr, a_req_wmask, a_req_wdata,
      output a_req_ready, a_resp_valid, a_resp_data,
      input  b_req_valid, b_req_write, b_req_addr, b_req_wmask, b_req_wdata,
      output b_req_ready, b_resp_valid, b_resp_data,
      output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
      input  sram_rdata,
      output init_done
   );

   modport master (
      output a_req_valid, a_req_write, a_req_addr, a_req_wmask, a_req_wdata,
      input  a_req_ready, a_resp_valid, a_resp_data,
      output b_req_valid, b_req_write, b_req_addr, b_req_wmask, b_req_wdata,
      input  b_req_ready, b_resp_valid, b_resp_data,
      input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
      output sram_rdata,
      input  init_done
   );
endinterface
`default_nettype wire

// File: rtl/sram_rw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sram_rw_arbiter                                            |
// | Purpose : Zero-initialises a single-port SRAM after reset, then      |
// |           arbitrates two requesters onto it, one access per cycle,   |
// |           round-robin on contention. Reads answer one cycle later.   |
// | Ports   : clock, reset (async, active-high)                          |
// |           bus (slave) - requester A/B, SRAM command, init_done       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sram_rw_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 80,
   parameter int LANES  = 4
) (
   input  logic            clock,
   input  logic            reset,
   sram_rw_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_INIT = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] init_cnt_q;
   logic              ptr_q;          // 0 = A has priority, 1 = B has priority
   logic              a_resp_valid_q;
   logic              b_resp_valid_q;
   logic              init_done_q;

   logic              grant_a;
   logic              grant_b;

   // A sole valid requester always wins; on contention the pointer decides.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state_q == ST_RUN) begin
         grant_a = bus.a_req_valid & (~bus.b_req_valid | ~ptr_q);
         grant_b = bus.b_req_valid & (~bus.a_req_valid |  ptr_q);
      end
   end

   assign bus.a_req_ready  = grant_a;
   assign bus.b_req_ready  = grant_b;
   assign bus.a_resp_valid = a_resp_valid_q;
   assign bus.b_resp_valid = b_resp_valid_q;
   // The SRAM returns read data one cycle after the command, which is exactly
   // the cycle the registered resp_valid is high, so data passes straight through.
   assign bus.a_resp_data  = bus.sram_rdata;
   assign bus.b_resp_data  = bus.sram_rdata;
   assign bus.init_done    = init_done_q;

   always_comb begin
      bus.sram_en    = 1'b0;
      bus.sram_wmode = 1'b0;
      bus.sram_addr  = '0;
      bus.sram_wmask = '0;
      bus.sram_wdata = '0;
      if (state_q == ST_INIT) begin
         bus.sram_en    = 1'b1;
         bus.sram_wmode = 1'b1;
         bus.sram_addr  = init_cnt_q;
         bus.sram_wmask = '1;
      end else if (grant_a) begin
         bus.sram_en    = 1'b1;
         bus.sram_wmode = bus.a_req_write;
         bus.sram_addr  = bus.a_req_addr;
         bus.sram_wmask = bus.a_req_wmask;
         bus.sram_wdata = bus.a_req_wdata;
      end else if (grant_b) begin
         bus.sram_en    = 1'b1;
         bus.sram_wmode = bus.b_req_write;
         bus.sram_addr  = bus.b_req_addr;
         bus.sram_wmask = bus.b_req_wmask;
         bus.sram_wdata = bus.b_req_wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_WAIT;
         init_cnt_q     <= '0;
         ptr_q          <= 1'b0;
         a_resp_valid_q <= 1'b0;
         b_resp_valid_q <= 1'b0;
         init_done_q    <= 1'b0;
      end else begin
         // Grants only happen in RUN, so these stay low elsewhere.
         a_resp_valid_q <= grant_a & ~bus.a_req_write;
         b_resp_valid_q <= grant_b & ~bus.b_req_write;
         case (state_q)
            ST_WAIT: state_q <= ST_INIT;
            ST_INIT: begin
               if (&init_cnt_q) begin
                  // Last address written: hold the counter, no second pass.
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end else begin
                  init_cnt_q <= init_cnt_q + ADDR_W'(1);
               end
            end
            ST_RUN: begin
               if (grant_a)      ptr_q <= 1'b1;
               else if (grant_b) ptr_q <= 1'b0;
            end
            default: state_q <= ST_WAIT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/sram_rw_arbiter.md
SRAM_RW_ARBITER -- requirements
Module: sram_rw_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning SRAM address width; DEPTH = 2^ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 80, meaning SRAM word width.
REQ-003 SHALL have parameter LANES, default 4, meaning write-mask lanes; DATA_W/LANES bits per lane.
REQ-004 SHALL have port clock  in  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports {a,b}_req_valid  in  1  requester has an access pending.
REQ-007 SHALL have ports {a,b}_req_ready  out  1  access accepted this cycle.
REQ-008 SHALL have ports {a,b}_req_write  in  1  1 = write, 0 = read.
REQ-009 SHALL have ports {a,b}_req_addr  in  ADDR_W  word address.
REQ-010 SHALL have ports {a,b}_req_wmask  in  LANES  per-lane write enable.
REQ-011 SHALL have ports {a,b}_req_wdata  in  DATA_W  write data.
REQ-012 SHALL have ports {a,b}_resp_valid  out  1  read data valid.
REQ-013 SHALL have ports {a,b}_resp_data  out  DATA_W  read data.
REQ-014 SHALL have port sram_en  out  1  SRAM single-port (RW0) enable.
REQ-015 SHALL have port sram_wmode  out  1  SRAM write mode.
REQ-016 SHALL have ports sram_addr / sram_wmask / sram_wdata  out  ADDR_W / LANES / DATA_W  SRAM command.
REQ-017 SHALL have port sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read command.
REQ-018 SHALL have port init_done  out  1  initialisation complete.

Function
REQ-019 SHALL implement states WAIT (reset state), INIT and RUN; WAIT -> INIT after one cycle; INIT -> RUN after the write to DEPTH-1; RUN is held until reset.
REQ-020 SHALL, in WAIT, drive sram_en=0 and both req_ready=0.
REQ-021 SHALL, in INIT, issue exactly one write per cycle with address init_cnt, wmask all-ones and wdata zero, for DEPTH consecutive cycles (addresses 0 to DEPTH-1 in order).
REQ-022 SHALL keep both req_ready=0 and init_done=0 in WAIT and INIT; init_done=1 in RUN.
REQ-023 SHALL size init_cnt at ADDR_W bits and leave INIT on the cycle init_cnt=DEPTH-1 without wrapping back to a second pass.
REQ-024 SHALL, in RUN, grant at most one requester per cycle: the sole valid requester, or, if both are valid, the one selected by the round-robin pointer.
REQ-025 SHALL assert req_ready combinationally only for the granted requester; a handshake is valid & ready in the same cycle.
REQ-026 SHALL move the round-robin pointer to the non-granted requester after each granted cycle, and leave it unchanged in cycles with no grant.
REQ-027 SHALL drive the SRAM command combinationally from the granted request (sram_en=1, sram_wmode=req_write, addr/wmask/wdata passed through), and drive sram_en=0 when there is no grant.
REQ-028 SHALL register a read grant and assert that requester's resp_valid for exactly one cycle, the cycle after the grant, with resp_data = sram_rdata.
REQ-029 SHALL produce no response for writes; a write with wmask=0 is still granted and occupies the cycle.
REQ-030 SHALL sustain one access per cycle, including back-to-back reads from either or alternating requesters.
REQ-031 SHALL require each requester to hold valid and its payload stable until ready; behaviour on early withdrawal is unspecified.
REQ-032 SHALL drive resp_data as don't-care when resp_valid=0.

Reset
REQ-033 SHALL, on reset assertion at any time (including mid-INIT or with a read response pending), immediately force: state=WAIT, init_cnt=0, pointer=A, {a,b}_resp_valid=0, {a,b}_req_ready=0, sram_en=0, init_done=0.
REQ-034 SHALL discard any pending read response on reset and restart the full INIT sequence after release.

Verification
REQ-035 Release reset, DEPTH=64 -> 1 idle cycle, then 64 writes to addresses 0..63 with data 0 and wmask 4'hF; init_done rises on the 66th cycle after release; reading any address then returns 0.
REQ-036 RUN; A writes addr 5, data 80'h1234, wmask 4'b0001; B then reads addr 5 -> b_resp_valid one cycle after b_req_ready, b_resp_data = 80'h1234.
REQ-037 RUN; A and B hold valid reads for 4 cycles -> grants A,B,A,B; each resp_valid pulses one cycle after its own grant.
REQ-038 Only B valid for 3 cycles, then A and B valid together -> B is granted 3 times, then A wins the simultaneous cycle (pointer points to A after each B grant).
REQ-039 Assert reset while INIT is at address 30 -> sram_en=0 immediately; after release the sequence restarts at address 0.
REQ-040 Assert reset in the cycle after a read grant -> resp_valid stays 0; no response is delivered after release.
